// File: rtl/leg_alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One transaction in flight: grant in IDLE, drive the ALU in EXEC, hold the result in RESP.
module leg_alu_arbiter #(
   parameter int UUID = 0,
   parameter     NAME = ""
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_op,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_op,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0] r_state;
   logic       r_ptr;
   logic       r_owner;
   logic [7:0] r_op;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_rsp_data;

   logic w_idle;
   logic w_exec;
   logic w_resp;
   logic w_gnt0;
   logic w_gnt1;
   logic w_done;

   // r_ptr high means requester 1 wins a tie; a lone requester always wins.
   always_comb begin
      w_idle = (r_state == S_IDLE);
      w_exec = (r_state == S_EXEC);
      w_resp = (r_state == S_RESP);
      w_gnt1 = w_idle & req1_valid & (~req0_valid | r_ptr);
      w_gnt0 = w_idle & req0_valid & ~w_gnt1;
      w_done = w_resp & (r_owner ? rsp1_ready : rsp0_ready);
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign rsp0_valid = w_resp & ~r_owner;
   assign rsp1_valid = w_resp & r_owner;
   assign rsp_data   = r_rsp_data;
   assign alu_op     = w_exec ? r_op : 8'd0;
   assign alu_a      = w_exec ? r_a  : 8'd0;
   assign alu_b      = w_exec ? r_b  : 8'd0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= 1'b0;
         r_owner    <= 1'b0;
         r_op       <= 8'd0;
         r_a        <= 8'd0;
         r_b        <= 8'd0;
         r_rsp_data <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 | w_gnt1) begin
                  r_state <= S_EXEC;
                  r_owner <= w_gnt1;
                  r_ptr   <= w_gnt0;
                  r_op    <= w_gnt1 ? req1_op : req0_op;
                  r_a     <= w_gnt1 ? req1_a  : req0_a;
                  r_b     <= w_gnt1 ? req1_b  : req0_b;
               end
            end
            S_EXEC: begin
               r_rsp_data <= alu_result;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (w_done) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
